// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared state encoding, special instruction words and entry widths for the fetch path
package rv_fetch_pkg;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int PC_W = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO with flush whose head is held in output registers
module fetch_queue import rv_fetch_pkg::*; #(
    parameter int QDEPTH = 2,
    parameter int W = ENTRY_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [W-1:0]              wdata,
    output logic [$clog2(QDEPTH):0]   count,
    output logic                      head_valid,
    output logic [W-1:0]              head_data
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [QDEPTH];
    logic [AW-1:0] rd, wr, rd_n;
    logic [CW-1:0] rem;
    // entries surviving the pop and the read pointer they leave behind
    always_comb begin
        rem = count - CW'(pop);
        rd_n = rd + AW'(pop);
    end
    // head registers take the next surviving entry, or the pushed word when nothing older remains
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
            head_valid <= 1'b0;
            if (reset) head_data <= '0;
        end else begin
            if (push) begin
                mem[wr] <= wdata;
                wr <= wr + AW'(1);
            end
            rd <= rd_n;
            count <= rem + CW'(push);
            head_valid <= rem != '0 || push;
            if (rem != '0) head_data <= mem[rd_n];
            else if (push) head_data <= wdata;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/FSM owner feeding decode from instruction memory; FETCH_PERF_CNT_EN adds perf counters
module fetch_sequencer import rv_fetch_pkg::*; #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [31:0]       imem_instruction,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instruction,
    output logic [31:0]       out_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    state_t state;
    logic [31:0] pc;
    logic [CW-1:0] count;
    logic pop, push;
    logic [ENTRY_W-1:0] head;
    assign imem_address = pc[ADDR_W+1:2];
    assign halted = state == S_HALT;
    assign {out_pc, out_instruction} = head;
    // a same-cycle pop frees a slot so a full queue still streams at one word per cycle
    always_comb begin
        pop = out_valid & out_ready;
        push = state == S_RUN && !redirect_valid && (count != FULL || pop);
    end
    fetch_queue #(.QDEPTH(QDEPTH), .W(ENTRY_W)) u_queue (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .wdata({pc, imem_instruction}),
        .count(count),
        .head_valid(out_valid),
        .head_data(head)
    );
    // redirect overrides everything but reset; EBREAK is still enqueued before halting
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            state <= S_RUN;
            pc <= redirect_pc & ~32'd3;
        end else if (state == S_BOOT) begin
            state <= S_RUN;
        end else if (push) begin
            pc <= pc + 32'd4;
            if (imem_instruction == EBREAK_WORD) state <= S_HALT;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    // free-running event counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_stall <= perf_stall + 32'(state == S_RUN && count == FULL && !pop && !redirect_valid);
            perf_flush <= perf_flush + 32'(redirect_valid && count != '0);
        end
    end
`endif
endmodule
